// File: rtl/sm_seq_chk_multi.sv
// sm_seq_chk_multi: N_CH independent two-input sequence checkers.
// Each channel runs an IDLE/S1/S2/ERROR Moore machine with filtered ERROR
// recovery, a saturating error-entry counter and a sequence-complete pulse.
// A global enable freezes every channel.
module sm_seq_chk_multi #(
  parameter int N_CH        = 4,
  parameter int RECOVER_CYC = 1,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr_cnt,
  input  logic [N_CH-1:0]       i1,
  input  logic [N_CH-1:0]       i2,
  output logic [N_CH-1:0]       o1,
  output logic [N_CH-1:0]       o2,
  output logic [N_CH-1:0]       err,
  output logic [N_CH-1:0]       done,
  output logic [N_CH*CNT_W-1:0] err_cnt,
  output logic                  any_err
);

  // Recovery counter must reach RECOVER_CYC-1; keep at least one bit.
  localparam int RC_W = (RECOVER_CYC + 1 > 2) ? $clog2(RECOVER_CYC + 1) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RECOVER_CYC - 1);

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_S1   = 3'b001;
  localparam logic [2:0] ST_S2   = 3'b010;
  localparam logic [2:0] ST_ERR  = 3'b100;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  // Counter update: a clear wins over the old value, but an ERROR entry
  // in the same cycle still counts as the first entry after the clear.
  function automatic logic [CNT_W-1:0] cnt_update(input logic [CNT_W-1:0] v,
                                                  input logic             clr,
                                                  input logic             entry);
    if (clr)   return entry ? CNT_W'(1) : '0;
    if (entry) return sat_inc(v);
    return v;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [RC_W-1:0]  rc;
    logic [RC_W-1:0]  rc_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             entry;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             o1_c;
    logic             o2_c;
    logic             err_c;

    // State, recovery counter, done pulse and error counter registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state  <= ST_IDLE;
        rc     <= '0;
        done_q <= 1'b0;
        cnt    <= '0;
      end else begin
        state  <= state_nxt;
        rc     <= rc_nxt;
        done_q <= done_nxt;
        cnt    <= cnt_nxt;
      end
    end

    // Next-state, recovery filter, done and counter logic for this channel.
    always_comb begin
      state_nxt = state;
      rc_nxt    = '0;
      done_nxt  = 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && i1[k]) state_nxt = i2[k] ? ST_S1 : ST_ERR;
        end
        ST_S1: begin
          if (en && i2[k]) state_nxt = i1[k] ? ST_S2 : ST_ERR;
        end
        ST_S2: begin
          if (en && !i2[k]) begin
            if (i1[k]) begin
              state_nxt = ST_IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = ST_ERR;
            end
          end
        end
        ST_ERR: begin
          // A single i1 high restarts the count of quiet cycles.
          rc_nxt = rc;
          if (en) begin
            if (i1[k]) begin
              rc_nxt = '0;
            end else if (rc == RC_LAST) begin
              state_nxt = ST_IDLE;
              rc_nxt    = '0;
            end else begin
              rc_nxt = rc + RC_W'(1);
            end
          end
        end
        // Illegal codes recover to IDLE even while disabled.
        default: state_nxt = ST_IDLE;
      endcase
      entry   = (state != ST_ERR) && (state_nxt == ST_ERR);
      cnt_nxt = cnt_update(cnt, clr_cnt, entry);
    end

    // Moore output decode from the registered state only.
    always_comb begin
      o1_c  = 1'b0;
      o2_c  = 1'b0;
      err_c = 1'b0;
      case (state)
        ST_S1:   o1_c = 1'b1;
        ST_S2:   o2_c = 1'b1;
        ST_ERR: begin
          o1_c  = 1'b1;
          o2_c  = 1'b1;
          err_c = 1'b1;
        end
        default: ;
      endcase
    end

    assign o1[k]                      = o1_c;
    assign o2[k]                      = o2_c;
    assign err[k]                     = err_c;
    assign done[k]                    = done_q;
    assign err_cnt[k*CNT_W +: CNT_W]  = cnt;
  end

  assign any_err = |err;

endmodule

// File: tb/tb_sm_seq_chk_multi.sv
// Directed testbench for sm_seq_chk_multi (N_CH=4, RECOVER_CYC=3, CNT_W=2).
module tb_sm_seq_chk_multi;
  localparam int N_CH = 4;
  localparam int RC   = 3;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              clr_cnt;
  logic [N_CH-1:0]   i1;
  logic [N_CH-1:0]   i2;
  logic [N_CH-1:0]   o1;
  logic [N_CH-1:0]   o2;
  logic [N_CH-1:0]   err;
  logic [N_CH-1:0]   done;
  logic [N_CH*CW-1:0] err_cnt;
  logic              any_err;

  int n_chk  = 0;
  int n_fail = 0;

  sm_seq_chk_multi #(.N_CH(N_CH), .RECOVER_CYC(RC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
    .i1(i1), .i2(i2), .o1(o1), .o2(o2), .err(err), .done(done),
    .err_cnt(err_cnt), .any_err(any_err)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] oce(input int k);
    return {o1[k], o2[k], err[k]};
  endfunction

  function automatic logic [CW-1:0] cnt_of(input int k);
    return err_cnt[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an ERROR entry on channel k, then three quiet cycles back to IDLE.
  task automatic error_cycle(input int k);
    i1 = '0; i2 = '0; i1[k] = 1'b1;
    step();
    i1 = '0;
    repeat (RC) step();
  endtask

  task automatic test_reset();
    // ch0 -> S1 and ch1 -> ERROR, then ch0 -> S2 while ch1 starts recovery
    i1 = 4'b0011; i2 = 4'b0001; step();
    i1 = 4'b0001; i2 = 4'b0001; step();
    n_chk++; if (oce(0) !== 3'b010) begin n_fail++; $display("FAIL rst_pre_ch0: got %b want 010", oce(0)); end
    n_chk++; if (oce(1) !== 3'b111) begin n_fail++; $display("FAIL rst_pre_ch1: got %b want 111", oce(1)); end
    n_chk++; if (cnt_of(1) !== 2'd1) begin n_fail++; $display("FAIL rst_pre_cnt1: got %0d want 1", cnt_of(1)); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if ({o1, o2, err, done} !== 16'h0) begin n_fail++; $display("FAIL rst_async_out: got %h want 0", {o1, o2, err, done}); end
    n_chk++; if (err_cnt !== '0 || any_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_cnt: got %h/%b want 0/0", err_cnt, any_err); end
    #1 rst = 1'b0;
    i1 = '0; i2 = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++; if ({o1, o2, err, done} !== 16'h0) begin n_fail++; $display("FAIL rst_idle_hold%0d: got %h want 0", c, {o1, o2, err, done}); end
    end
  endtask

  task automatic test_good_seq();
    i1 = 4'b0100; i2 = 4'b0100; step();
    n_chk++; if (oce(2) !== 3'b100) begin n_fail++; $display("FAIL good_s1: got %b want 100", oce(2)); end
    n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL good_done_s1: got %b want 0000", done); end
    step();
    n_chk++; if (oce(2) !== 3'b010) begin n_fail++; $display("FAIL good_s2: got %b want 010", oce(2)); end
    i1 = 4'b0100; i2 = 4'b0000; step();
    n_chk++; if (oce(2) !== 3'b000) begin n_fail++; $display("FAIL good_idle: got %b want 000", oce(2)); end
    n_chk++; if (done !== 4'b0100) begin n_fail++; $display("FAIL good_done: got %b want 0100", done); end
    i1 = '0; step();
    n_chk++; if (done !== 4'b0000) begin n_fail++; $display("FAIL good_done_once: got %b want 0000", done); end
    n_chk++; if (cnt_of(2) !== 2'd0) begin n_fail++; $display("FAIL good_cnt2: got %0d want 0", cnt_of(2)); end
  endtask

  task automatic test_err_recover();
    logic [5:0] pat;
    logic [5:0] exp_err;
    pat     = 6'b000100;  // applied LSB first: 0,0,1,0,0,0
    exp_err = 6'b011111;  // err after each of those edges, LSB first
    i1 = 4'b0001; i2 = 4'b0000; step();
    n_chk++; if (oce(0) !== 3'b111) begin n_fail++; $display("FAIL rec_entry: got %b want 111", oce(0)); end
    n_chk++; if (any_err !== 1'b1) begin n_fail++; $display("FAIL rec_any_err: got %b want 1", any_err); end
    n_chk++; if (cnt_of(0) !== 2'd1) begin n_fail++; $display("FAIL rec_cnt: got %0d want 1", cnt_of(0)); end
    for (int c = 0; c < 6; c++) begin
      i1 = {3'b000, pat[c]}; step();
      n_chk++; if (err[0] !== exp_err[c]) begin n_fail++; $display("FAIL rec_err%0d: got %b want %b", c, err[0], exp_err[c]); end
    end
    n_chk++; if (any_err !== 1'b0) begin n_fail++; $display("FAIL rec_any_clear: got %b want 0", any_err); end
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    n_chk++; if (err_cnt !== '0) begin n_fail++; $display("FAIL sat_clr: got %h want 0", err_cnt); end
    for (int e = 0; e < 5; e++) begin
      i1 = 4'b0001; i2 = '0; step();
      n_chk++; if (cnt_of(0) !== exp_cnt[e]) begin n_fail++; $display("FAIL sat_entry%0d: got %0d want %0d", e, cnt_of(0), exp_cnt[e]); end
      i1 = '0; repeat (RC) step();
    end
  endtask

  task automatic test_clr_collision();
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    error_cycle(1);
    error_cycle(1);
    n_chk++; if (cnt_of(1) !== 2'd2) begin n_fail++; $display("FAIL clr_pre_ch1: got %0d want 2", cnt_of(1)); end
    clr_cnt = 1'b1; i1 = 4'b1000; i2 = '0; step();
    clr_cnt = 1'b0;
    n_chk++; if (cnt_of(3) !== 2'd1) begin n_fail++; $display("FAIL clr_ch3: got %0d want 1", cnt_of(3)); end
    n_chk++; if (cnt_of(1) !== 2'd0) begin n_fail++; $display("FAIL clr_ch1: got %0d want 0", cnt_of(1)); end
    n_chk++; if (err !== 4'b1000) begin n_fail++; $display("FAIL clr_err: got %b want 1000", err); end
    i1 = '0; repeat (RC) step();
  endtask

  task automatic test_enable();
    i1 = 4'b0001; i2 = 4'b0001; step();
    n_chk++; if (oce(0) !== 3'b100) begin n_fail++; $display("FAIL en_s1: got %b want 100", oce(0)); end
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_chk++; if (oce(0) !== 3'b100 || done !== 4'b0000) begin n_fail++; $display("FAIL en_hold%0d: got %b/%b want 100/0000", c, oce(0), done); end
      n_chk++; if (err_cnt !== 8'b0100_0000) begin n_fail++; $display("FAIL en_cnt%0d: got %b want 01000000", c, err_cnt); end
    end
    en = 1'b1; step();
    n_chk++; if (oce(0) !== 3'b010) begin n_fail++; $display("FAIL en_resume: got %b want 010", oce(0)); end
    i1 = 4'b0001; i2 = 4'b0000; step();
    n_chk++; if (done !== 4'b0001) begin n_fail++; $display("FAIL en_done: got %b want 0001", done); end
    i1 = '0; step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr_cnt = 1'b0; i1 = '0; i2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({o1, o2, err, done, err_cnt, any_err} !== 25'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", {o1, o2, err, done, err_cnt, any_err}); end
    rst = 1'b0;
    test_reset();
    test_good_seq();
    test_err_recover();
    test_saturation();
    test_clr_collision();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
